// File: rtl/riscv_pkg.sv
// riscv_pkg: shared LSU state encoding and RV32I load/store size codes.
package riscv_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte enables, store lane steering, load extraction/extension and legality check.
module lsu_lane_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        illegal
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;
    logic        bad_f3;

    always_comb begin
        b          = rdata[{off, 3'b000} +: 8];
        h          = off[1] ? rdata[31:16] : rdata[15:0];
        sx         = ~funct3[2];
        rdata_ext  = funct3[1:0] == 2'b00 ? {{24{sx & b[7]}}, b} :
                     funct3[1:0] == 2'b01 ? {{16{sx & h[15]}}, h} : rdata;
        be         = (!we || funct3[1]) ? 4'b1111 : (funct3[0] ? 4'b0011 : 4'b0001) << off;
        wdata_lane = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                     funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        bad_f3     = we ? !(funct3 inside {LSU_B, LSU_H, LSU_W})
                        : !(funct3 inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU});
        illegal    = bad_f3 || (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
    end
endmodule

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: turns core loads/stores into valid/ready bus transactions, stalling until done.
module lsu_bus_bridge
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              misalign,
    output logic              bus_err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_rvalid
);
    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_t        state, state_nx;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              idle, busy, tmo, illegal, start, err_nx;
    logic [3:0]        be_a;
    logic [31:0]       wd_a, rd_a;

    assign idle  = state == IDLE;
    assign busy  = state == REQ || state == WAIT;
    assign tmo   = busy && cnt == CW'(TIMEOUT - 1);
    assign start = idle && req_valid && !illegal;

    // In IDLE the aligner sees the live request; afterwards it decodes the latched one for the read lane.
    lsu_lane_align u_align (
        .funct3    (idle ? req_funct3 : f3_q),
        .we        (idle ? req_we : we_q),
        .off       (idle ? req_addr[1:0] : addr_q[1:0]),
        .wdata     (req_wdata),
        .rdata     (bus_rdata),
        .be        (be_a),
        .wdata_lane(wd_a),
        .rdata_ext (rd_a),
        .illegal   (illegal)
    );

    assign misalign  = idle && req_valid && illegal;
    assign stall     = start || busy;
    assign bus_valid = state == REQ;
    assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus_we    = we_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? REQ : IDLE;
            REQ:     state_nx = tmo ? DONE : bus_ready ? WAIT : REQ;
            WAIT:    state_nx = (bus_rvalid || tmo) ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
        err_nx = tmo && !(state == WAIT && bus_rvalid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            load_data <= '0;
            bus_err   <= 1'b0;
        end else begin
            cnt     <= busy ? cnt + 1'b1 : '0;
            bus_err <= err_nx;
            if (start) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                f3_q    <= req_funct3;
                be_q    <= be_a;
                wdata_q <= wd_a;
            end
            if (state == WAIT && bus_rvalid && !we_q) load_data <= rd_a;
            else if (err_nx && !we_q)                 load_data <= '0;
        end
    end
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb_lsu_bus_bridge: directed vector table plus hand sequences for stalls, timeout and reset abort.
module tb_lsu_bus_bridge;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_we, bus_ready, bus_rvalid;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, bus_rdata;
    logic        stall, misalign, bus_err, bus_valid, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    int          errors = 0;
    int          checks = 0;

    lsu_bus_bridge #(.TIMEOUT(8), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .load_data(load_data),
        .misalign(misalign), .bus_err(bus_err), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        logic        mis;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] bwd, ld;
    } vec_t;

    typedef struct {
        int          stalls;
        bit          saw_valid, done;
        logic        mis;
        logic [31:0] addr, wdata, ld;
        logic [3:0]  be;
        logic        we, err, valid_done;
    } res_t;

    vec_t v[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one access from IDLE; ready after ready_wait REQ cycles, rvalid after rvalid_wait WAIT cycles.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int ready_wait, input int rvalid_wait, input bit rv_never,
                          output res_t r);
        int rq = 0, wt = 0;
        bit acc = 0;
        r = '{default: 0};
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; bus_rdata = rdata;
        for (int c = 0; c < 40 && !r.done; c++) begin
            bus_ready  = rq >= ready_wait;
            bus_rvalid = acc && !rv_never && wt >= rvalid_wait;
            #2;
            if (c == 0) r.mis = misalign;
            if (bus_valid) begin
                r.saw_valid = 1; r.addr = bus_addr; r.be = bus_be; r.wdata = bus_wdata; r.we = bus_we;
            end
            if (!stall) begin
                r.done = 1; r.ld = load_data; r.err = bus_err; r.valid_done = bus_valid;
                req_valid = 0;
            end else r.stalls++;
            if (bus_valid) begin
                if (bus_ready) acc = 1;
                rq++;
            end else if (acc && stall) wt++;
            @(posedge clk); #1;
        end
        bus_ready = 0; bus_rvalid = 0; req_valid = 0;
        chk("access completes", 32'(r.done), 32'd1);
    endtask

    initial begin
        res_t r;
        v[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0};
        v[1]  = '{1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0,        1'b0, 32'h100, 4'h8, 32'hA5A5A5A5, 32'h0};
        v[2]  = '{1'b0, 3'd0, 32'h102, 32'h0,        32'h0080FF11, 1'b0, 32'h100, 4'hF, 32'h0,        32'hFFFFFF80};
        v[3]  = '{1'b0, 3'd4, 32'h102, 32'h0,        32'h0080FF11, 1'b0, 32'h100, 4'hF, 32'h0,        32'h00000080};
        v[4]  = '{1'b1, 3'd1, 32'h102, 32'h0000BEEF, 32'h0,        1'b0, 32'h100, 4'hC, 32'hBEEFBEEF, 32'h00000080};
        v[5]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h80011234, 1'b0, 32'h100, 4'hF, 32'h0,        32'hFFFF8001};
        v[6]  = '{1'b0, 3'd5, 32'h102, 32'h0,        32'h80011234, 1'b0, 32'h100, 4'hF, 32'h0,        32'h00008001};
        v[7]  = '{1'b0, 3'd1, 32'h100, 32'h0,        32'h80011234, 1'b0, 32'h100, 4'hF, 32'h0,        32'h00001234};
        v[8]  = '{1'b0, 3'd2, 32'h204, 32'h0,        32'hCAFEF00D, 1'b0, 32'h204, 4'hF, 32'h0,        32'hCAFEF00D};
        v[9]  = '{1'b1, 3'd0, 32'h101, 32'h12345677, 32'h0,        1'b0, 32'h100, 4'h2, 32'h77777777, 32'hCAFEF00D};
        v[10] = '{1'b0, 3'd1, 32'h101, 32'h0,        32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'hCAFEF00D};
        v[11] = '{1'b0, 3'd3, 32'h100, 32'h0,        32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'hCAFEF00D};
        v[12] = '{1'b1, 3'd2, 32'h101, 32'h1,        32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'hCAFEF00D};
        v[13] = '{1'b1, 3'd1, 32'h103, 32'h1,        32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'hCAFEF00D};
        v[14] = '{1'b1, 3'd4, 32'h100, 32'h1,        32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'hCAFEF00D};
        v[15] = '{1'b0, 3'd6, 32'h100, 32'h0,        32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'hCAFEF00D};

        rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("rst bus_valid", 32'(bus_valid), 32'd0);
        chk("rst bus_we", 32'(bus_we), 32'd0);
        chk("rst bus_be", 32'(bus_be), 32'd0);
        chk("rst bus_addr", bus_addr, 32'd0);
        chk("rst bus_wdata", bus_wdata, 32'd0);
        chk("rst load_data", load_data, 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            access(v[i].we, v[i].f3, v[i].addr, v[i].wdata, v[i].rdata, 0, 0, 0, r);
            chk($sformatf("v%0d misalign", i), 32'(r.mis), 32'(v[i].mis));
            chk($sformatf("v%0d load_data", i), r.ld, v[i].ld);
            if (v[i].mis) begin
                chk($sformatf("v%0d no bus_valid", i), 32'(r.saw_valid), 32'd0);
                chk($sformatf("v%0d stalls", i), 32'(r.stalls), 32'd0);
                #1 chk($sformatf("v%0d idle after", i), 32'({bus_valid, stall}), 32'd0);
            end else begin
                chk($sformatf("v%0d stalls", i), 32'(r.stalls), 32'd3);
                chk($sformatf("v%0d bus_addr", i), r.addr, v[i].baddr);
                chk($sformatf("v%0d bus_be", i), 32'(r.be), 32'(v[i].be));
                chk($sformatf("v%0d bus_we", i), 32'(r.we), 32'(v[i].we));
                chk($sformatf("v%0d bus_err", i), 32'(r.err), 32'd0);
                if (v[i].we) chk($sformatf("v%0d bus_wdata", i), r.wdata, v[i].bwd);
            end
        end

        access(1'b0, 3'd2, 32'h108, 32'h0, 32'h12345678, 2, 1, 0, r);
        chk("slow lw stalls", 32'(r.stalls), 32'd6);
        chk("slow lw load_data", r.ld, 32'h12345678);
        chk("slow lw bus_err", 32'(r.err), 32'd0);

        access(1'b0, 3'd2, 32'h10C, 32'h0, 32'h55555555, 0, 0, 1, r);
        chk("timeout stalls", 32'(r.stalls), 32'd9);
        chk("timeout bus_err", 32'(r.err), 32'd1);
        chk("timeout load_data", r.ld, 32'd0);
        chk("timeout bus_valid", 32'(r.valid_done), 32'd0);
        #1 chk("bus_err clears", 32'(bus_err), 32'd0);

        access(1'b0, 3'd2, 32'h200, 32'h0, 32'hA1B2C3D4, 0, 0, 0, r);
        chk("reload load_data", r.ld, 32'hA1B2C3D4);

        // Abort a load in WAIT with reset, then show a late rvalid is ignored.
        req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h300; bus_ready = 1; bus_rdata = 32'h99999999;
        @(posedge clk); #1;
        #1 chk("abort in REQ", 32'(bus_valid), 32'd1);
        @(posedge clk); #1;
        #1 chk("abort in WAIT", 32'({bus_valid, stall}), 32'b01);
        rst = 1; req_valid = 0; bus_ready = 0;
        @(posedge clk); #1 rst = 0;
        #1;
        chk("abort bus_valid", 32'(bus_valid), 32'd0);
        chk("abort stall", 32'(stall), 32'd0);
        chk("abort load_data", load_data, 32'd0);
        bus_rvalid = 1;
        @(posedge clk); #1 bus_rvalid = 0;
        @(posedge clk); #1;
        chk("late rvalid load_data", load_data, 32'd0);
        chk("late rvalid stall", 32'(stall), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store unit directly downstream of the core's data-memory port.
- Consumes the effective address (ALU result), store data, write strobe and funct3, and returns load data.
- Converts each access into a valid/ready bus transaction with byte enables and load sign/zero extension.
- Stalls the core until the access completes, errors or times out.

Parameters:
- TIMEOUT, 255: maximum bus cycles (REQ+WAIT) before abort. Counter width is $clog2(TIMEOUT+1).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a load or store this cycle.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I size/sign field.
- req_addr  in  ADDR_W  effective byte address.
- req_wdata  in  32  store data (rs2).
- stall  out  1  core must hold PC and request stable.
- load_data  out  32  aligned, extended load result (core readdata).
- misalign  out  1  misaligned address or illegal funct3. Combinational, IDLE only.
- bus_err  out  1  timeout abort, asserted in DONE.
- bus_valid  out  1  request to memory.
- bus_ready  in  1  memory accepts request.
- bus_addr  out  ADDR_W  word address, bits[1:0]=00.
- bus_we  out  1  write request.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-steered store data.
- bus_rdata  in  32  read word.
- bus_rvalid  in  1  read data / write acknowledge.

Behaviour:
- State machine, states IDLE, REQ, WAIT, DONE. Reset forces IDLE on the next edge.
- Reset values: bus_valid=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, load_data=0, bus_err=0, timeout counter=0.
- IDLE:
  - req_valid=1 with legal alignment and funct3: stall=1 combinationally in the same cycle. Latch addr/we/be/wdata/funct3 into request registers, go to REQ.
  - req_valid=1 with illegal alignment or funct3: misalign=1, stall=0, no bus access, stay IDLE.
- REQ: bus_valid=1 from the latched registers. On bus_valid&bus_ready go to WAIT. stall=1.
- WAIT: bus_valid=0, stall=1. On bus_rvalid:
  - load: load_data <= extended lane data.
  - store: load_data unchanged.
  - go to DONE.
- DONE: stall=0 (core retires on this edge), then IDLE. load_data holds until the next completed load.
- A new req_valid in the cycle after DONE starts a fresh access.
- Minimum latency, with ready and rvalid at first opportunity: 3 stalled cycles (IDLE, REQ, WAIT), then DONE.
- bus_rvalid is sampled only in WAIT. The slave must not assert it in the acceptance cycle. rvalid in IDLE, REQ or DONE is ignored.
- Timeout: counter clears on IDLE→REQ and increments each REQ/WAIT cycle. On reaching TIMEOUT:
  - go to DONE with bus_err=1 and bus_valid=0;
  - load: load_data=0.
  - bus_err clears on leaving DONE.
- Byte lanes, with off=addr[1:0]:
  - SB: be=0001<<off, wdata={4{byte}}.
  - SH: be=0011<<off, wdata={2{half}}.
  - SW: be=1111.
  - LB/LBU: byte at lane off, sign- or zero-extended.
  - LH/LHU: half at lane addr[1], sign- or zero-extended.
  - LW: whole word.
  - Load reads drive be=1111.
- Legal funct3:
  - loads: 000, 001, 010, 100, 101.
  - stores: 000, 001, 010.
- Misaligned accesses: halfword with off[0]=1; word with off≠0.
- Reset mid-transaction: IDLE on the next edge, bus_valid=0, any in-flight response discarded. The slave must tolerate the dropped transaction.

Decomposition:
- riscv_pkg:
  - lsu_state_t enum {IDLE, REQ, WAIT, DONE};
  - funct3 constants LSU_B=3'b000, LSU_H=3'b001, LSU_W=3'b010, LSU_BU=3'b100, LSU_HU=3'b101.
- One combinational sub-module, lsu_lane_align: funct3, offset, wdata, rdata → be, steered wdata, extended rdata, illegal flag.

Test Plan:
- Case 1: SW addr=0x100, wdata=0xDEADBEEF, ready=1, rvalid next cycle → bus_addr=0x100, be=1111, wdata=0xDEADBEEF. stall high 3 cycles, low in DONE.
- Case 2: SB addr=0x103, wdata=0x000000A5 → be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x100.
- Case 3: LB addr=0x102, rdata=0x0080FF11 → load_data=0xFFFFFF80. Same address with LBU → 0x00000080.
- Case 4: LH addr=0x101 → misalign=1, stall=0, bus_valid never asserted. funct3=011 load → misalign=1.
- Case 5: LW with bus_ready=0 for 3 cycles then rvalid after 2 more, rdata=0x12345678 → load_data=0x12345678, stall high 6 cycles. Then, with TIMEOUT=8 and rvalid never arriving: DONE after 8 bus cycles with bus_err=1, load_data=0.
- Case 6: rst=1 while in WAIT → next cycle IDLE, bus_valid=0, load_data=0. A late rvalid is ignored and load_data stays 0.
